// File: rtl/stepper_pkg.sv
// stepper_pkg: shared constants, quadrature encoding and helpers for the stepper encoder emulator
package stepper_pkg;

    localparam logic [4:0] ADDR_ENC_COUNT = 5'h0;
    localparam logic [4:0] ADDR_USTEP_POS = 5'h1;
    localparam logic [4:0] ADDR_PENDING   = 5'h2;
    localparam logic [4:0] ADDR_STATUS    = 5'h3;
    localparam logic [4:0] ADDR_ENDSTOP   = 5'h4;
    localparam logic [4:0] ADDR_PHASE     = 5'h5;

    localparam int STAT_OVERFLOW = 0;
    localparam int STAT_BUSY     = 1;

    // encoded as {B,A}
    typedef enum logic [1:0] {
        QUAD_00 = 2'b00,
        QUAD_01 = 2'b01,
        QUAD_11 = 2'b11,
        QUAD_10 = 2'b10
    } quad_t;

    function automatic logic [4:0] ms_weight(input logic [1:0] ms);
        return ms == 2'b00 ? 5'd16 : ms == 2'b01 ? 5'd8 : ms == 2'b10 ? 5'd4 : 5'd2;
    endfunction

    function automatic quad_t quad_next(input quad_t q);
        return q == QUAD_00 ? QUAD_01 : q == QUAD_01 ? QUAD_11 : q == QUAD_11 ? QUAD_10 : QUAD_00;
    endfunction

    function automatic quad_t quad_prev(input quad_t q);
        return q == QUAD_00 ? QUAD_10 : q == QUAD_10 ? QUAD_11 : q == QUAD_11 ? QUAD_01 : QUAD_00;
    endfunction

endpackage

// File: rtl/stepper_encoder_emulator_quadrature_encoder.sv
// quadrature_encoder: drains the pending-count backlog into rate-limited A/B/I quadrature edges
module quadrature_encoder
    import stepper_pkg::*;
#(
    parameter int COUNTS_PER_REV = 8192,
    parameter int MIN_EDGE_CLKS  = 50,
    parameter int PENDING_MAX    = 65535
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               norm_inc,
    input  logic               norm_dec,
    input  logic               load,
    input  logic        [31:0] load_count,
    output logic signed [31:0] pending,
    output logic        [31:0] enc_count,
    output quad_t              phase,
    output logic               index,
    output logic               saturated
);
    localparam int TW = MIN_EDGE_CLKS > 1 ? $clog2(MIN_EDGE_CLKS) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(MIN_EDGE_CLKS - 1);
    localparam logic signed [33:0] PMAX = 34'(PENDING_MAX);
    localparam int CPR = COUNTS_PER_REV;

    logic        [TW-1:0] timer_q, timer_d;
    logic signed [31:0]   pending_q, pending_d;
    logic        [31:0]   enc_q, enc_d;
    quad_t                phase_q, phase_d;
    logic                 index_q, index_d;
    logic                 advance, fwd;
    logic signed [33:0]   sum;

    always_comb begin
        advance   = timer_q == TIMER_MAX && pending_q != 0;
        fwd       = !pending_q[31];
        sum       = 34'(pending_q) + (norm_inc ? 34'sd1 : 34'sd0) - (norm_dec ? 34'sd1 : 34'sd0)
                  - (advance ? (fwd ? 34'sd1 : -34'sd1) : 34'sd0);
        saturated = !load && (sum > PMAX || sum < -PMAX);
        pending_d = load ? '0 : sum > PMAX ? 32'(PMAX) : sum < -PMAX ? 32'(-PMAX) : sum[31:0];
        enc_d     = load ? load_count : !advance ? enc_q : fwd ? enc_q + 32'd1 : enc_q - 32'd1;
        phase_d   = load ? QUAD_00 : !advance ? phase_q : fwd ? quad_next(phase_q) : quad_prev(phase_q);
        timer_d   = advance ? '0 : timer_q == TIMER_MAX ? timer_q : timer_q + TW'(1);
        // index is re-evaluated only when position moves, so it stays low out of reset
        index_d   = (load || advance) ? (phase_d == QUAD_00 && ($signed(enc_d) % CPR) == 0) : index_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q   <= TIMER_MAX;
            pending_q <= '0;
            enc_q     <= '0;
            phase_q   <= QUAD_00;
            index_q   <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            enc_q     <= enc_d;
            phase_q   <= phase_d;
            index_q   <= index_d;
        end
    end

    assign pending   = pending_q;
    assign enc_count = enc_q;
    assign phase     = phase_q;
    assign index     = index_q;

endmodule

// File: rtl/stepper_encoder_emulator.sv
// stepper_encoder_emulator: integrates step/dir into shaft position and regenerates encoder feedback
module stepper_encoder_emulator
    import stepper_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ  = 50_000_000,
    parameter int COUNTS_PER_REV = 8192,
    parameter int STEPS_PER_REV  = 200,
    parameter int MIN_EDGE_CLKS  = 50,
    parameter int PENDING_MAX    = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        step,
    input  logic        dir,
    input  logic        enable,
    input  logic [1:0]  MS,
    output logic        A,
    output logic        B,
    output logic        I,
    output logic        endswitch
);
    localparam logic signed [39:0] THRESH = 40'(16 * STEPS_PER_REV);
    localparam logic signed [39:0] CPR40  = 40'(COUNTS_PER_REV);

    logic [4:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic               step_prev_q, step_prev_d;
    logic               evt_q, evt_d, evt_dir_q, evt_dir_d;
    logic [4:0]         evt_w_q, evt_w_d;
    logic [31:0]        ustep_q, ustep_d, endstop_q, endstop_d;
    logic signed [39:0] residue_q, residue_d, delta;
    logic               overflow_q, overflow_d;
    logic               wr_enc, norm_inc, norm_dec, saturated, index;
    logic signed [31:0] pending;
    logic [31:0]        enc_count;
    quad_t              phase;
    logic               unused;

    assign unused = read ^ (CLOCK_FREQ_HZ == 0);

    // synchroniser bit order: {MS, enable, dir, step}
    always_comb begin
        sync1_d     = {MS, enable, dir, step};
        sync2_d     = sync1_q;
        step_prev_d = sync2_q[0];
        evt_d       = sync2_q[0] && !step_prev_q && !sync2_q[2];
        evt_dir_d   = sync2_q[1];
        evt_w_d     = ms_weight(sync2_q[4:3]);
        wr_enc      = write && address == ADDR_ENC_COUNT;
        delta       = CPR40 * $signed({35'd0, evt_w_q});
        norm_inc    = residue_q >= THRESH;
        norm_dec    = residue_q[39];
        ustep_d     = (write && address == ADDR_USTEP_POS) ? writedata : !evt_q ? ustep_q
                    : evt_dir_q ? ustep_q + 32'(evt_w_q) : ustep_q - 32'(evt_w_q);
        residue_d   = wr_enc ? '0 : residue_q + (!evt_q ? 40'sd0 : evt_dir_q ? delta : -delta)
                    - (norm_inc ? THRESH : 40'sd0) + (norm_dec ? THRESH : 40'sd0);
        overflow_d  = (write && address == ADDR_STATUS) ? 1'b0 : overflow_q || saturated;
        endstop_d   = (write && address == ADDR_ENDSTOP) ? writedata : endstop_q;
        endswitch   = $signed(enc_count) > $signed(endstop_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            step_prev_q <= 1'b0;
            evt_q       <= 1'b0;
            evt_dir_q   <= 1'b0;
            evt_w_q     <= '0;
            ustep_q     <= '0;
            residue_q   <= '0;
            overflow_q  <= 1'b0;
            endstop_q   <= 32'h8000_0000;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            step_prev_q <= step_prev_d;
            evt_q       <= evt_d;
            evt_dir_q   <= evt_dir_d;
            evt_w_q     <= evt_w_d;
            ustep_q     <= ustep_d;
            residue_q   <= residue_d;
            overflow_q  <= overflow_d;
            endstop_q   <= endstop_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_ENC_COUNT: readdata = enc_count;
            ADDR_USTEP_POS: readdata = ustep_q;
            ADDR_PENDING:   readdata = pending;
            ADDR_STATUS: begin
                readdata[STAT_OVERFLOW] = overflow_q;
                readdata[STAT_BUSY]     = pending != 0;
            end
            ADDR_ENDSTOP:   readdata = endstop_q;
            ADDR_PHASE:     readdata = {30'd0, phase};
            default:        readdata = '0;
        endcase
    end

    quadrature_encoder #(
        .COUNTS_PER_REV(COUNTS_PER_REV),
        .MIN_EDGE_CLKS (MIN_EDGE_CLKS),
        .PENDING_MAX   (PENDING_MAX)
    ) u_enc (
        .clk       (clk),
        .reset_n   (reset_n),
        .norm_inc  (norm_inc),
        .norm_dec  (norm_dec),
        .load      (wr_enc),
        .load_count(writedata),
        .pending   (pending),
        .enc_count (enc_count),
        .phase     (phase),
        .index     (index),
        .saturated (saturated)
    );

    assign A = phase[0];
    assign B = phase[1];
    assign I = index;

endmodule

// File: tb/tb_stepper_encoder_emulator.sv
// tb_stepper_encoder_emulator: directed checks on a default, a fast-edge and a small-saturation instance
module tb_stepper_encoder_emulator;
    logic clk, reset_n, reset_n_sat, write, read, step, dir, enable;
    logic [4:0] address;
    logic [1:0] MS;
    logic [31:0] writedata, rd0, rd1, rd2;
    logic A0, B0, I0, es0, A1, B1, I1, es1, A2, B2, I2, es2;
    int checks = 0, passed = 0;
    logic mon_fast = 1'b0;
    logic i1_prev = 1'b0;
    int fast_viol = 0, fast_rises = 0;

    stepper_encoder_emulator dut (
        .clk(clk), .reset_n(reset_n), .write(write), .read(read), .address(address),
        .writedata(writedata), .readdata(rd0), .step(step), .dir(dir), .enable(enable),
        .MS(MS), .A(A0), .B(B0), .I(I0), .endswitch(es0));

    stepper_encoder_emulator #(.MIN_EDGE_CLKS(2)) dut_fast (
        .clk(clk), .reset_n(reset_n), .write(write), .read(read), .address(address),
        .writedata(writedata), .readdata(rd1), .step(step), .dir(dir), .enable(enable),
        .MS(MS), .A(A1), .B(B1), .I(I1), .endswitch(es1));

    stepper_encoder_emulator #(.MIN_EDGE_CLKS(1000), .PENDING_MAX(300)) dut_sat (
        .clk(clk), .reset_n(reset_n_sat), .write(write), .read(read), .address(address),
        .writedata(writedata), .readdata(rd2), .step(step), .dir(dir), .enable(enable),
        .MS(MS), .A(A2), .B(B2), .I(I2), .endswitch(es2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mon_fast) begin
        if (I1 !== ({B1, A1} == 2'b00 && (rd1 % 32'd8192) == 0)) fast_viol++;
        if (I1 && !i1_prev) fast_rises++;
        i1_prev = I1;
    end

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return p == 2'b00 ? 2'b01 : p == 2'b01 ? 2'b11 : p == 2'b11 ? 2'b10 : 2'b00;
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic pulse(input logic d);
        dir = d; step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        repeat (3) @(negedge clk);
        reset_n = 1'b1; reset_n_sat = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (A0 !== 1'b0) $display("FAIL reset_A: got %0b want 0", A0); else passed++;
        checks++; if (B0 !== 1'b0) $display("FAIL reset_B: got %0b want 0", B0); else passed++;
        checks++; if (I0 !== 1'b0) $display("FAIL reset_I: got %0b want 0", I0); else passed++;
        checks++; if (es0 !== 1'b1) $display("FAIL reset_endswitch: got %0b want 1", es0); else passed++;
        for (int a = 0; a < 8; a++) begin
            address = 5'(a);
            #1;
            exp = (a == 4) ? 32'h8000_0000 : 32'h0;
            checks++; if (rd0 !== exp) $display("FAIL reset_reg%0d: got %h want %h", a, rd0, exp); else passed++;
        end
    endtask

    task automatic test_single_step();
        int first = -1, edges = 0, bad_gap = 0, bad_seq = 0, last = 0;
        logic [1:0] prev;
        @(negedge clk);
        address = 5'h0; prev = {B0, A0};
        dir = 1'b1; step = 1'b1;
        for (int i = 1; i <= 2200; i++) begin
            @(negedge clk);
            if (i == 3) step = 1'b0;
            if ({B0, A0} != prev) begin
                if (edges == 0) first = i;
                else if (i - last != 50) bad_gap++;
                if ({B0, A0} != nxt(prev)) bad_seq++;
                edges++; last = i; prev = {B0, A0};
            end
        end
        checks++; if (first < 1 || first > 6) $display("FAIL first_edge_latency: got %0d want 1..6", first); else passed++;
        checks++; if (edges != 40) $display("FAIL edge_count: got %0d want 40", edges); else passed++;
        checks++; if (bad_gap != 0) $display("FAIL edge_spacing: got %0d bad gaps want 0", bad_gap); else passed++;
        checks++; if (bad_seq != 0) $display("FAIL edge_order: got %0d bad steps want 0", bad_seq); else passed++;
        #1;
        checks++; if (rd0 !== 32'd40) $display("FAIL single_enc: got %0d want 40", rd0); else passed++;
        address = 5'h1; #1;
        checks++; if (rd0 !== 32'd16) $display("FAIL single_ustep: got %0d want 16", rd0); else passed++;
        address = 5'h2; #1;
        checks++; if (rd0 !== 32'd0) $display("FAIL single_pending: got %0d want 0", rd0); else passed++;
        checks++; if (dut.residue_q !== 40'sd3072) $display("FAIL single_residue: got %0d want 3072", dut.residue_q); else passed++;
    endtask

    task automatic test_full_rev();
        @(negedge clk);
        MS = 2'b00;
        wr(5'h0, 32'd0);
        address = 5'h0; #1;
        checks++; if (I1 !== 1'b1) $display("FAIL rev_index_start: got %0b want 1", I1); else passed++;
        i1_prev = 1'b1; fast_viol = 0; fast_rises = 0; mon_fast = 1'b1;
        @(negedge clk);
        repeat (200) pulse(1'b1);
        for (int i = 0; i < 25000 && rd1 != 32'd8192; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++; if (rd1 !== 32'd8192) $display("FAIL rev_fwd_enc: got %0d want 8192", rd1); else passed++;
        checks++; if (I1 !== 1'b1) $display("FAIL rev_fwd_index: got %0b want 1", I1); else passed++;
        checks++; if (fast_rises != 1) $display("FAIL rev_fwd_index_rises: got %0d want 1", fast_rises); else passed++;
        repeat (200) pulse(1'b0);
        for (int i = 0; i < 25000 && rd1 != 32'd0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        mon_fast = 1'b0;
        checks++; if (rd1 !== 32'd0) $display("FAIL rev_back_enc: got %0d want 0", rd1); else passed++;
        checks++; if (I1 !== 1'b1) $display("FAIL rev_back_index: got %0b want 1", I1); else passed++;
        checks++; if (fast_rises != 2) $display("FAIL rev_back_index_rises: got %0d want 2", fast_rises); else passed++;
        checks++; if (fast_viol != 0) $display("FAIL rev_index_exact: got %0d bad cycles want 0", fast_viol); else passed++;
    endtask

    task automatic test_disable();
        wr(5'h0, 32'd0);
        wr(5'h1, 32'd0);
        MS = 2'b11; enable = 1'b0;
        repeat (4) @(negedge clk);
        repeat (8) pulse(1'b1);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        repeat (5) pulse(1'b1);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (2200) @(negedge clk);
        address = 5'h1; #1;
        checks++; if (rd0 !== 32'd16) $display("FAIL disable_ustep: got %0d want 16", rd0); else passed++;
        address = 5'h0; #1;
        checks++; if (rd0 !== 32'd40) $display("FAIL disable_enc: got %0d want 40", rd0); else passed++;
    endtask

    task automatic test_endstop();
        int viol = 0, falls = 0;
        logic [31:0] fall_val = '1;
        logic prev_es;
        @(negedge clk);
        MS = 2'b00;
        wr(5'h4, 32'd100);
        wr(5'h0, 32'd120);
        address = 5'h0; #1;
        checks++; if (es0 !== 1'b1) $display("FAIL endstop_initial: got %0b want 1", es0); else passed++;
        prev_es = es0;
        dir = 1'b0; step = 1'b1;
        for (int i = 1; i <= 2300; i++) begin
            @(negedge clk);
            if (i == 3) step = 1'b0;
            if (es0 !== ($signed(rd0) > 32'sd100)) viol++;
            if (prev_es && !es0) begin falls++; fall_val = rd0; end
            prev_es = es0;
        end
        checks++; if (viol != 0) $display("FAIL endstop_compare: got %0d bad cycles want 0", viol); else passed++;
        checks++; if (falls != 1 || fall_val !== 32'd100) $display("FAIL endstop_fall: got %0d falls at %0d want 1 at 100", falls, fall_val); else passed++;
        checks++; if (rd0 !== 32'd79) $display("FAIL endstop_final_enc: got %0d want 79", rd0); else passed++;
    endtask

    task automatic test_saturation();
        int moves = 0;
        logic [1:0] prev;
        @(negedge clk);
        wr(5'h0, 32'd0);
        wr(5'h3, 32'd0);
        address = 5'h3; #1;
        checks++; if (rd2 !== 32'd0) $display("FAIL sat_status_clear0: got %h want 0", rd2); else passed++;
        MS = 2'b00; enable = 1'b0;
        repeat (20) pulse(1'b1);
        repeat (380) @(negedge clk);
        address = 5'h2; #1;
        checks++; if (rd2 !== 32'd300) $display("FAIL sat_pending: got %0d want 300", rd2); else passed++;
        address = 5'h3; #1;
        checks++; if (rd2 !== 32'd3) $display("FAIL sat_status: got %h want 3", rd2); else passed++;
        repeat (500) @(negedge clk);
        wr(5'h3, 32'd0);
        address = 5'h3; #1;
        checks++; if (rd2 !== 32'd2) $display("FAIL sat_status_cleared: got %h want 2", rd2); else passed++;
        @(negedge clk);
        reset_n_sat = 1'b0;
        #2;
        checks++; if ({B2, A2, I2} !== 3'b000) $display("FAIL sat_reset_outputs: got %b want 000", {B2, A2, I2}); else passed++;
        address = 5'h2; #1;
        checks++; if (rd2 !== 32'd0) $display("FAIL sat_reset_pending: got %0d want 0", rd2); else passed++;
        address = 5'h0; #1;
        checks++; if (rd2 !== 32'd0) $display("FAIL sat_reset_enc: got %0d want 0", rd2); else passed++;
        @(negedge clk);
        reset_n_sat = 1'b1;
        prev = {B2, A2};
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ({B2, A2} != prev) moves++;
            prev = {B2, A2};
        end
        checks++; if (moves != 0) $display("FAIL sat_no_trailing_edges: got %0d edges want 0", moves); else passed++;
        address = 5'h2; #1;
        checks++; if (rd2 !== 32'd0) $display("FAIL sat_pending_after: got %0d want 0", rd2); else passed++;
    endtask

    initial begin
        write = 1'b0; read = 1'b0; address = '0; writedata = '0;
        step = 1'b0; dir = 1'b1; enable = 1'b0; MS = 2'b00;
        reset_n = 1'b0; reset_n_sat = 1'b0;
        test_reset();
        test_single_step();
        test_full_rev();
        test_disable();
        test_endstop();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
